lb_host_bridge: RTL and testbench

Avalon-MM slave to local-bus master bridge placed directly upstream of the cortex acceleration engine. It accepts single read/write transactions from the Nios/host interconnect, replays each as a one-cycle `lb_wr_en`/`lb_rd_en` strobe on cortex's local bus, and waits for `lb_wr_valid`/`lb_rd_valid`. Read data returns on `avs_readdata`. A bounded timeout keeps the host from hanging on unmapped or dead blocks.

---
 rtl/lb_host_bridge_if.sv | 40 ++++
 rtl/lb_host_bridge.sv | 117 +++++++++++
 tb/tb_lb_host_bridge.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lb_host_bridge_if.sv
// lb_host_bridge_if: groups the bridge's Avalon-MM slave signals and its
// local-bus master signals into one bundle.
// The "slave" modport is the bridge's view of the bundle.
// The "master" modport is the view of the host and cortex around it.
interface lb_host_bridge_if #(
  parameter int LB_DATA_W = 32,
  parameter int LB_ADDR_W = 16
);
  // Avalon-MM host side
  logic [LB_ADDR_W-1:0] avs_address;
  logic                 avs_read;
  logic                 avs_write;
  logic [LB_DATA_W-1:0] avs_writedata;
  logic                 avs_waitrequest;
  logic                 avs_readdatavalid;
  logic [LB_DATA_W-1:0] avs_readdata;

  // cortex local-bus side
  logic                 lb_wr_en;
  logic                 lb_rd_en;
  logic [LB_ADDR_W-1:0] lb_addr;
  logic [LB_DATA_W-1:0] lb_wr_data;
  logic                 lb_wr_valid;
  logic                 lb_rd_valid;
  logic [LB_DATA_W-1:0] lb_rd_data;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    input  lb_wr_valid, lb_rd_valid, lb_rd_data,
    output avs_waitrequest, avs_readdatavalid, avs_readdata,
    output lb_wr_en, lb_rd_en, lb_addr, lb_wr_data
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    output lb_wr_valid, lb_rd_valid, lb_rd_data,
    input  avs_waitrequest, avs_readdatavalid, avs_readdata,
    input  lb_wr_en, lb_rd_en, lb_addr, lb_wr_data
  );
endinterface

// File: rtl/lb_host_bridge.sv
// lb_host_bridge: Avalon-MM slave to cortex local-bus master bridge.
// Each accepted host read or write is replayed as a one-cycle lb_rd_en or
// lb_wr_en strobe. The bridge then waits for the matching valid. A bounded
// wait keeps the host from hanging on dead or unmapped blocks.
// Optional feature: define LB_HOST_BRIDGE_TOUT_CNT_EN to build the
// saturating timeout counter on tout_cnt. Without that macro, tout_cnt is
// tied to 0.
module lb_host_bridge #(
  parameter int                   LB_DATA_W        = 32,
  parameter int                   LB_ADDR_W        = 16,
  parameter int                   TIMEOUT_CYCLES   = 64,
  parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe
) (
  input  logic                  clk,
  input  logic                  rst,
  lb_host_bridge_if.slave       bus,
  output logic [15:0]           tout_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_WAIT = 2'd1,
    RD_WAIT = 2'd2,
    RD_RESP = 2'd3
  } state_t;

  localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        timeout_hit;

  assign timeout_hit = (wait_cnt == TOUT_LAST);

  // Host is only accepted in IDLE, so waitrequest is a pure state decode
  assign bus.avs_waitrequest = (state != IDLE);

  // Main FSM: accept, strobe the local bus, wait for valid or timeout, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      wait_cnt              <= '0;
      bus.lb_wr_en          <= 1'b0;
      bus.lb_rd_en          <= 1'b0;
      bus.lb_addr           <= '0;
      bus.lb_wr_data        <= '0;
      bus.avs_readdatavalid <= 1'b0;
      bus.avs_readdata      <= '0;
    end else begin
      bus.lb_wr_en          <= 1'b0;
      bus.lb_rd_en          <= 1'b0;
      bus.avs_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (bus.avs_write) begin
            bus.lb_addr    <= bus.avs_address;
            bus.lb_wr_data <= bus.avs_writedata;
            bus.lb_wr_en   <= 1'b1;
            state          <= WR_WAIT;
          end else if (bus.avs_read) begin
            bus.lb_addr  <= bus.avs_address;
            bus.lb_rd_en <= 1'b1;
            state        <= RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (bus.lb_wr_valid || timeout_hit) begin
            state <= IDLE;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RD_WAIT: begin
          if (bus.lb_rd_valid) begin
            bus.avs_readdata      <= bus.lb_rd_data;
            bus.avs_readdatavalid <= 1'b1;
            state                 <= RD_RESP;
          end else if (timeout_hit) begin
            bus.avs_readdata      <= DEFAULT_DATA_VAL;
            bus.avs_readdatavalid <= 1'b1;
            state                 <= RD_RESP;
          end else if (wait_cnt != 16'hFFFF) begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RD_RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef LB_HOST_BRIDGE_TOUT_CNT_EN
  logic tout_evt;

  // A valid arriving in the timeout cycle wins, so it does not count here
  assign tout_evt = timeout_hit &&
                    (((state == WR_WAIT) && !bus.lb_wr_valid) ||
                     ((state == RD_WAIT) && !bus.lb_rd_valid));

  // Saturating count of timeouts, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tout_cnt <= '0;
    end else if (tout_evt && (tout_cnt != 16'hFFFF)) begin
      tout_cnt <= tout_cnt + 16'd1;
    end
  end
`else
  assign tout_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_lb_host_bridge.sv
// tb_lb_host_bridge: randomized, scoreboarded bench for lb_host_bridge.
// The host driver pushes the expected local-bus strobes, busy lengths and
// read responses into queues. Independent monitors pop these entries and
// compare them whenever the bridge presents an output.
module tb_lb_host_bridge;

  localparam int          TO  = 64;
  localparam logic [31:0] DEF = 32'hdeadbabe;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rd_exp_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] data;
  } lb_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] tout_cnt;

  lb_host_bridge_if #(.LB_DATA_W(32), .LB_ADDR_W(16)) bus();

  lb_host_bridge #(
    .LB_DATA_W(32), .LB_ADDR_W(16), .TIMEOUT_CYCLES(TO), .DEFAULT_DATA_VAL(DEF)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .tout_cnt(tout_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails  = 0;
  int          cyc    = 0;
  int          busy_run = 0;
  int          exp_tout = 0;
  rd_exp_t     rd_q[$];
  lb_exp_t     lb_q[$];
  int          busy_q[$];

  bit          resp_give  = 1'b0;
  int          resp_delay = 0;
  logic [31:0] resp_data  = '0;
  logic        resp_is_wr;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Free-running cycle index: during the cycle after an edge it holds that edge's number
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: busy-run lengths, local-bus strobes and read responses against the queues
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (bus.avs_waitrequest) begin
        busy_run++;
      end else if (busy_run > 0) begin
        if (busy_q.size() == 0) checkOutput("unexpected_busy", 64'(busy_run), 64'd0);
        else checkOutput("busy_len", 64'(busy_run), 64'(busy_q.pop_front()));
        busy_run = 0;
      end
      if (bus.lb_wr_en || bus.lb_rd_en) begin
        if (lb_q.size() == 0) begin
          checkOutput("unexpected_lb_strobe", {bus.lb_wr_en, bus.lb_rd_en}, 64'd0);
        end else begin
          lb_exp_t e;
          e = lb_q.pop_front();
          checkOutput("lb_wr_en", bus.lb_wr_en, e.wr);
          checkOutput("lb_rd_en", bus.lb_rd_en, !e.wr);
          checkOutput("lb_addr", bus.lb_addr, e.addr);
          if (e.wr) checkOutput("lb_wr_data", bus.lb_wr_data, e.data);
        end
      end
      if (bus.avs_readdatavalid) begin
        if (rd_q.size() == 0) begin
          checkOutput("unexpected_readdatavalid", bus.avs_readdatavalid, 64'd0);
        end else begin
          rd_exp_t r;
          r = rd_q.pop_front();
          checkOutput("readdata", bus.avs_readdata, r.data);
          checkOutput("readdatavalid_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
    end
  end

  // cortex model: answers a strobe after resp_delay cycles, or stays silent
  initial begin
    bus.lb_wr_valid = 1'b0;
    bus.lb_rd_valid = 1'b0;
    bus.lb_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && (bus.lb_wr_en || bus.lb_rd_en) && resp_give) begin
        resp_is_wr = bus.lb_wr_en;
        repeat (resp_delay) @(negedge clk);
        if (resp_is_wr) begin
          bus.lb_wr_valid = 1'b1;
        end else begin
          bus.lb_rd_valid = 1'b1;
          bus.lb_rd_data  = resp_data;
        end
        @(negedge clk);
        bus.lb_wr_valid = 1'b0;
        bus.lb_rd_valid = 1'b0;
        bus.lb_rd_data  = $urandom;
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while (bus.avs_waitrequest && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkOutput("idle_timeout", bus.avs_waitrequest, 64'd0);
  endtask

  // kind: 0 = read, 1 = write, 2 = read and write together.
  // A delay counts cycles after the strobe; give=0 means no answer arrives.
  task automatic applyStimulus(input int kind, input logic [15:0] addr, input logic [31:0] data,
                               input int delay, input bit give, input logic [31:0] rdata);
    int      t;
    lb_exp_t e;
    rd_exp_t r;
    waitIdle();
    checkOutput("tout_cnt", tout_cnt, 64'(exp_tout));
    resp_give  = give;
    resp_delay = delay;
    resp_data  = rdata;
    t = cyc + 1;
    e.wr   = (kind != 0);
    e.addr = addr;
    e.data = data;
    lb_q.push_back(e);
    if (kind != 0) begin
      busy_q.push_back(give ? delay + 1 : TO);
    end else begin
      busy_q.push_back(give ? delay + 2 : TO + 1);
      r.cyc  = give ? t + 1 + delay : t + TO;
      r.data = give ? rdata : DEF;
      rd_q.push_back(r);
    end
`ifdef LB_HOST_BRIDGE_TOUT_CNT_EN
    if (!give && exp_tout < 65535) exp_tout++;
`endif
    bus.avs_address   = addr;
    bus.avs_writedata = data;
    bus.avs_read      = (kind != 1);
    bus.avs_write     = (kind != 0);
    @(negedge clk);
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_address   = $urandom;
    bus.avs_writedata = $urandom;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required finish before limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.avs_address   = '0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_waitrequest", bus.avs_waitrequest, 64'd0);
    checkOutput("rst_readdatavalid", bus.avs_readdatavalid, 64'd0);
    checkOutput("rst_readdata", bus.avs_readdata, 64'd0);
    checkOutput("rst_lb_en", {bus.lb_wr_en, bus.lb_rd_en}, 64'd0);
    checkOutput("rst_tout_cnt", tout_cnt, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed transactions");
    applyStimulus(0, 16'h1004, 32'h0, 3, 1'b1, 32'hCAFE0001);
    applyStimulus(1, 16'h2000, 32'h12345678, 0, 1'b1, 32'h0);
    applyStimulus(0, 16'h0040, 32'h0, 0, 1'b0, 32'h0);
    applyStimulus(0, 16'h0044, 32'h0, TO - 1, 1'b1, 32'hA5A55A5A);
    applyStimulus(2, 16'h3000, 32'h0BADF00D, 2, 1'b1, 32'h0);
    applyStimulus(1, 16'h3004, 32'h11112222, 0, 1'b0, 32'h0);

    $display("[TB] reset during read wait");
    waitIdle();
    checkOutput("tout_cnt_pre_rst", tout_cnt, 64'(exp_tout));
    begin
      lb_exp_t e;
      e.wr = 1'b0; e.addr = 16'h4000; e.data = '0;
      lb_q.push_back(e);
    end
    resp_give       = 1'b0;
    bus.avs_address = 16'h4000;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("midrst_waitrequest", bus.avs_waitrequest, 64'd0);
    checkOutput("midrst_lb_addr", bus.lb_addr, 64'd0);
    checkOutput("midrst_readdata", bus.avs_readdata, 64'd0);
    checkOutput("midrst_tout_cnt", tout_cnt, 64'd0);
    exp_tout = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.lb_rd_valid = 1'b1;
    bus.lb_rd_data  = 32'h11111111;
    @(negedge clk);
    bus.lb_rd_valid = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(0, 16'h4004, 32'h0, 1, 1'b1, 32'h76543210);

    $display("[TB] randomized transactions");
    for (int i = 0; i < 40; i++) begin
      int r;
      int kind;
      int d;
      bit give;
      r    = $urandom_range(0, 9);
      kind = $urandom_range(0, 2);
      give = (r >= 2);
      d    = (r == 2) ? TO - 1 : $urandom_range(0, 6);
      applyStimulus(kind, 16'($urandom), $urandom, d, give, $urandom);
    end

    waitIdle();
    repeat (3) @(negedge clk);
    checkOutput("final_tout_cnt", tout_cnt, 64'(exp_tout));
    checkOutput("rd_q_empty", 64'(rd_q.size()), 64'd0);
    checkOutput("lb_q_empty", 64'(lb_q.size()), 64'd0);
    checkOutput("busy_q_empty", 64'(busy_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
